load_unit: RTL

LOAD_UNIT -- requirements
Module: load_unit

---
 rtl/load_unit.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/load_unit.sv
// Load unit: accepts a CPU load request, computes base + sign-extended imm, issues a single
// one-cycle start pulse to the memory controller, waits for completion (with a timeout), and
// returns the raw read data (or a fault) on a valid/ready writeback port.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   req_*                CPU request: valid/ready handshake, base, imm (signed 12b), funct3, rd
//   mc_*                 memory controller: start pulse, address, mode (= funct3), done, read data
//   wb_*                 writeback: valid/ready handshake, rd, data, fault flag, fault code
//
// Fault codes: 00 none, 01 illegal funct3, 10 misaligned, 11 timeout.
//
// Configuration
//   LOAD_UNIT_MISALIGN_CHECK_EN  when defined, misaligned LH/LHU/LW fault with code 10 instead
//                                of being issued to the controller.
module load_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] base,
  input  logic [11:0] imm,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd,
  output logic        mc_start,
  output logic [31:0] mc_address,
  output logic [2:0]  mc_mode,
  input  logic        mc_done,
  input  logic [31:0] mc_read_data,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_fault,
  output logic [1:0]  wb_fault_code
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  localparam logic [1:0] FaultNone     = 2'b00;
  localparam logic [1:0] FaultIllegal  = 2'b01;
  localparam logic [1:0] FaultMisalign = 2'b10;
  localparam logic [1:0] FaultTimeout  = 2'b11;

  // Last WAIT cycle index on which mc_done is still honoured.
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  mode_q, mode_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] data_q, data_d;
  logic        fault_q, fault_d;
  logic [1:0]  code_q, code_d;
  logic [7:0]  cnt_q, cnt_d;

  logic [31:0] req_addr;
  logic        legal;
  logic        misalign;

  always_comb begin
    req_addr = base + {{20{imm[11]}}, imm};

    legal = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
      default:                                legal = 1'b0;
    endcase

`ifdef LOAD_UNIT_MISALIGN_CHECK_EN
    misalign = ((funct3 == 3'b001 || funct3 == 3'b101) && req_addr[0]) ||
               ((funct3 == 3'b010) && (req_addr[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    mode_d  = mode_q;
    rd_d    = rd_q;
    data_d  = data_q;
    fault_d = fault_q;
    code_d  = code_q;
    cnt_d   = cnt_q;

    case (state_q)
      StIdle: begin
        if (req_valid) begin
          addr_d  = req_addr;
          mode_d  = funct3;
          rd_d    = rd;
          data_d  = '0;
          cnt_d   = '0;
          fault_d = 1'b0;
          code_d  = FaultNone;
          if (!legal) begin
            state_d = StResp;
            fault_d = 1'b1;
            code_d  = FaultIllegal;
          end else if (misalign) begin
            state_d = StResp;
            fault_d = 1'b1;
            code_d  = FaultMisalign;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        state_d = StWait;
        cnt_d   = '0;
      end
      StWait: begin
        cnt_d = cnt_q + 8'd1;
        // A done on the final allowed cycle still wins over the timeout.
        if (mc_done) begin
          state_d = StResp;
          data_d  = mc_read_data;
          fault_d = 1'b0;
          code_d  = FaultNone;
        end else if (cnt_q == TimeoutLast) begin
          state_d = StResp;
          data_d  = '0;
          fault_d = 1'b1;
          code_d  = FaultTimeout;
        end
      end
      StResp: begin
        if (wb_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      mode_q  <= '0;
      rd_q    <= '0;
      data_q  <= '0;
      fault_q <= 1'b0;
      code_q  <= FaultNone;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      mode_q  <= mode_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      fault_q <= fault_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
    end
  end

  // All outputs come straight from state/registers, so they are glitch-free and reset-forced.
  assign req_ready     = (state_q == StIdle);
  assign mc_start      = (state_q == StIssue);
  assign mc_address    = addr_q;
  assign mc_mode       = mode_q;
  assign wb_valid      = (state_q == StResp);
  assign wb_rd         = rd_q;
  assign wb_data       = data_q;
  assign wb_fault      = fault_q;
  assign wb_fault_code = code_q;

endmodule
